uart_boot_loader: RTL and testbench

- Sits directly downstream of the UART receiver inside the cpu top level; consumes received bytes and writes the executable image into instruction memory.
- Packs bytes little-endian into 32-bit words: byte n goes to word n/4, lane n%4, and lane 0 is bits 7:0.
- Holds the CPU core in reset until WORD_COUNT words are written, then releases it.
- A reload pulse re-arms it so a new image can be loaded.

---
 rtl/uart_boot_loader_pkg.sv | 14 +
 rtl/uart_boot_loader_if.sv | 22 ++
 rtl/uart_boot_loader_byte_word_packer.sv | 39 +++
 rtl/uart_boot_loader.sv | 116 +++++++++++
 tb/tb_uart_boot_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: state encoding, word geometry and default image size.
// The CHECK state only exists when BOOT_CHECKSUM_EN is defined.
package uart_boot_loader_pkg;

    localparam int unsigned BYTES_PER_WORD     = 4;
    localparam int unsigned DEFAULT_WORD_COUNT = 13;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [1:0] {StLoad, StWrite, StCheck, StDone} state_e;
`else
    typedef enum logic [1:0] {StLoad, StWrite, StDone} state_e;
`endif

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte stream from the UART receiver in, instruction-memory write port out.
// master drives bytes and observes writes; slave is the boot loader.
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_frame_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output rx_valid, rx_byte, rx_frame_err,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_byte, rx_frame_err,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_boot_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: lane counter plus 32-bit assembly register.
// word_ready_o/word_o are combinational so the full word is visible in the cycle of the 4th byte.
module uart_boot_loader_byte_word_packer
    import uart_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q;
    logic [31:0] asm_q;

    always_comb begin
        word_o = asm_q;
        word_o[{lane_q, 3'b000} +: 8] = byte_i;
        word_ready_o = byte_valid_i && (lane_q == 2'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            lane_q <= 2'd0;
            asm_q  <= 32'd0;
        end else if (byte_valid_i) begin
            if (word_ready_o) begin
                lane_q <= 2'd0;
                asm_q  <= 32'd0;
            end else begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= word_o;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Writes a UART-received image into instruction memory and holds the CPU in reset until done.
// Optional BOOT_CHECKSUM_EN: a trailing mod-256 sum byte must match before the CPU is released.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    uart_boot_loader_if.slave   bus,
    input  logic                reload,
    output logic                cpu_hold,
    output logic                boot_done,
    output logic                err
);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              last_word;
    logic              good_byte;
    logic              bad_byte;
    logic              pack_valid;
    logic              word_ready;
    logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    assign last_word = (idx_q == ADDR_W'(WORD_COUNT - 1));
    assign good_byte = bus.rx_valid && !bus.rx_frame_err && !reload;
    assign bad_byte  = bus.rx_valid && bus.rx_frame_err && !reload;
    // A byte landing in the WRITE cycle starts the next word; after the last word it is not image data.
    assign pack_valid = good_byte &&
                        ((state_q == StLoad) || ((state_q == StWrite) && !last_word));

    uart_boot_loader_byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (reload),
        .byte_valid_i (pack_valid),
        .byte_i       (bus.rx_byte),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state_q   <= StLoad;
            idx_q     <= '0;
            cpu_hold  <= 1'b1;
            boot_done <= 1'b0;
            err       <= 1'b0;
            bus.mem_we <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
            // Address/data keep their last values across reload; only a full reset clears them.
            if (rst) begin
                bus.mem_addr  <= ADDR_W'(BASE_ADDR);
                bus.mem_wdata <= 32'd0;
            end
        end else begin
            bus.mem_we <= 1'b0;
            if (bad_byte && (state_q != StDone)) begin
                err <= 1'b1;
            end
`ifdef BOOT_CHECKSUM_EN
            if (pack_valid) begin
                sum_q <= sum_q + bus.rx_byte;
            end
`endif
            unique case (state_q)
                StLoad: begin
                    if (word_ready) begin
                        state_q       <= StWrite;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= ADDR_W'(BASE_ADDR) + idx_q;
                        bus.mem_wdata <= word;
                    end
                end
                StWrite: begin
                    idx_q <= idx_q + 1'b1;
                    if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                        state_q   <= StCheck;
`else
                        state_q   <= StDone;
                        cpu_hold  <= 1'b0;
                        boot_done <= 1'b1;
`endif
                    end else begin
                        state_q <= StLoad;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                StCheck: begin
                    if (good_byte) begin
                        if (bus.rx_byte == sum_q) begin
                            state_q   <= StDone;
                            cpu_hold  <= 1'b0;
                            boot_done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
`endif
                StDone: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: random images, framing errors, reload/reset, post-done bytes.
module tb_uart_boot_loader;

    localparam int unsigned WC   = 13;
    localparam int unsigned AW   = 8;
    localparam int unsigned BASE = 0;

    logic clk = 1'b0;
    logic rst;
    logic reload;
    logic cpu_hold;
    logic boot_done;
    logic err;

    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(AW)) bus ();

    uart_boot_loader #(
        .WORD_COUNT (WC),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .reload    (reload),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: image progress expressed as a byte count.
    int unsigned m_n;
    logic [31:0] m_word;
    logic [7:0]  m_sum;
    bit          m_done;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_word = 32'd0;
        m_sum  = 8'd0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit fe);
        if (fe) begin
            if (!m_done) m_err = 1'b1;
        end else if (!m_done) begin
            if (m_n == WC * 4) begin
                if (b == m_sum) m_done = 1'b1;
                else            m_err  = 1'b1;
            end else begin
                m_word[8 * (m_n % 4) +: 8] = b;
                m_sum = m_sum + b;
                m_n++;
                if (m_n % 4 == 0) begin
                    exp_q.push_back('{BASE + m_n / 4 - 1, m_word, m_n == WC * 4});
                    m_word = 32'd0;
`ifndef BOOT_CHECKSUM_EN
                    if (m_n == WC * 4) m_done = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fe, input int unsigned gap);
        model_byte(b, fe);
        bus.rx_valid     = 1'b1;
        bus.rx_byte      = b;
        bus.rx_frame_err = fe;
        tick();
        bus.rx_valid     = 1'b0;
        bus.rx_frame_err = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reload(input bit with_byte, input logic [7:0] b);
        reload = 1'b1;
        if (with_byte) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = b;
        end
        tick();
        reload       = 1'b0;
        bus.rx_valid = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic send_image(input bit bad_sum);
        logic [31:0] img [WC];
        logic [7:0]  b;
        img[0] = 32'h0050_0093;
        for (int w = 1; w < WC; w++) img[w] = $urandom;
        for (int w = 0; w < WC; w++) begin
            for (int l = 0; l < 4; l++) begin
                b = img[w][8 * l +: 8];
                send_byte(b, 1'b0, (w == WC - 1 && l == 3) ? 3 : $urandom_range(0, 4));
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(bad_sum ? (m_sum ^ 8'h01) : m_sum, 1'b0, 3);
`else
        if (bad_sum) tick();
`endif
    endtask

    task automatic check_status(input string tag);
        check({tag, "_boot_done"}, 32'(boot_done), 32'(m_done));
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'(!m_done));
        check({tag, "_err"},       32'(err),       32'(m_err));
    endtask

    // Monitor: pops the scoreboard on every memory write and checks the release timing.
    bit chk_after_last = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_after_last) begin
            chk_after_last = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            check("hold_after_last_write", 32'(cpu_hold), 32'd1);
            check("done_after_last_write", 32'(boot_done), 32'd0);
`else
            check("hold_after_last_write", 32'(cpu_hold), 32'd0);
            check("done_after_last_write", 32'(boot_done), 32'd1);
`endif
        end
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got write addr 0x%0h data 0x%08h, expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", 32'(bus.mem_addr), e.addr);
                check("mem_wdata", bus.mem_wdata, e.data);
                if (e.last) chk_after_last = 1'b1;
            end
        end
    end

    initial begin
        rst              = 1'b1;
        reload           = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_byte      = 8'd0;
        bus.rx_frame_err = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  BASE);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_cpu_hold",  32'(cpu_hold),      32'd1);
        check("rst_boot_done", 32'(boot_done),     32'd0);
        check("rst_err",       32'(err),           32'd0);
        rst = 1'b0;
        tick();

        // Full image.
        send_image(1'b0);
        repeat (2) tick();
        check_status("image1");

        // Bytes after DONE are ignored.
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 2);
        check_status("after_done");

        // Framing error then a clean word, reload after 6 good bytes, then a full image.
        do_reload(1'b0, 8'h00);
        check_status("reload1");
        send_byte(8'h11, 1'b1, 2);
        send_byte(8'h93, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        send_byte(8'h50, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        send_byte(8'h5a, 1'b0, 2);
        send_byte(8'ha5, 1'b0, 2);
        check_status("frame_err");
        do_reload(1'b0, 8'h00);
        send_image(1'b0);
        repeat (2) tick();
        check_status("image2");

        // reload wins over a simultaneous byte.
        do_reload(1'b1, 8'haa);
        check("reload_rx_cpu_hold", 32'(cpu_hold), 32'd1);
        send_image(1'b0);
        repeat (2) tick();
        check_status("image3");

        // Synchronous reset mid-load behaves like reload.
        do_reload(1'b0, 8'h00);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        send_image(1'b0);
        repeat (2) tick();
        check_status("image4");

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum keeps the CPU held until reload and a correct image.
        do_reload(1'b0, 8'h00);
        send_image(1'b1);
        repeat (2) tick();
        check_status("bad_sum");
        do_reload(1'b0, 8'h00);
        send_image(1'b0);
        repeat (2) tick();
        check_status("good_sum");
`endif

        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
